// File: rtl/wbu_multi_port.sv
// Write-back merge stage: per-channel result FIFOs, round-robin arbitration into the single
// GPR write port, and a pending-destination mask for ID-stage hazard checks.
module wbu_multi_port #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned XLEN   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic [NUM_CH*5-1:0]      ch_rd,
    input  logic [NUM_CH*XLEN-1:0]   ch_data,
    output logic                     gpr_wen,
    output logic [4:0]               gpr_waddr,
    output logic [XLEN-1:0]          gpr_wdata,
    output logic [31:0]              rd_busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned RW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [4:0]      rd_mem   [NUM_CH][DEPTH];
    logic [XLEN-1:0] data_mem [NUM_CH][DEPTH];

    logic [NUM_CH-1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [NUM_CH-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NUM_CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0]             rr_ptr_q, rr_ptr_d;
    logic                      gpr_wen_q, gpr_wen_d;
    logic [4:0]                gpr_waddr_q, gpr_waddr_d;
    logic [XLEN-1:0]           gpr_wdata_q, gpr_wdata_d;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic              grant_vld;
    logic [RW-1:0]     grant_idx;

    // Ready depends on occupancy only; rd==0 writes complete the handshake but are not stored.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ready[i] = (cnt_q[i] != CW'(DEPTH));
            req[i]      = (cnt_q[i] != '0);
            push[i]     = ch_valid[i] & ch_ready[i] & (ch_rd[5*i +: 5] != 5'd0) & ~flush;
        end
    end

    // Round-robin search starts just after the last granted channel.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            idx = (int'(rr_ptr_q) + k) % int'(NUM_CH);
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = RW'(idx);
            end
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        gpr_wen_d   = 1'b0;
        gpr_waddr_d = gpr_waddr_q;
        gpr_wdata_d = gpr_wdata_q;
        pop         = '0;

        if (grant_vld && !flush) begin
            pop[grant_idx] = 1'b1;
            gpr_wen_d      = 1'b1;
            gpr_waddr_d    = rd_mem[grant_idx][rd_ptr_q[grant_idx]];
            gpr_wdata_d    = data_mem[grant_idx][rd_ptr_q[grant_idx]];
            if (NUM_CH > 1) begin
                rr_ptr_d = grant_idx;
            end
        end

        for (int i = 0; i < NUM_CH; i++) begin
            if (flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                cnt_d[i]    = '0;
            end else begin
                wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
                rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
                cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end

        if (NUM_CH == 1) begin
            rr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            gpr_wen_q   <= 1'b0;
            gpr_waddr_q <= '0;
            gpr_wdata_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            gpr_wen_q   <= gpr_wen_d;
            gpr_waddr_q <= gpr_waddr_d;
            gpr_wdata_q <= gpr_wdata_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                rd_mem[i][wr_ptr_q[i]]   <= ch_rd[5*i +: 5];
                data_mem[i][wr_ptr_q[i]] <= ch_data[XLEN*i +: XLEN];
            end
        end
    end

    // An entry is live when its offset from the read pointer is below the count.
    always_comb begin
        logic [PW-1:0] offs;
        offs    = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
                offs = PW'(j) - rd_ptr_q[i];
                if (CW'(offs) < cnt_q[i]) begin
                    rd_busy[rd_mem[i][j]] = 1'b1;
                end
            end
        end
        if (gpr_wen_q) begin
            rd_busy[gpr_waddr_q] = 1'b1;
        end
    end

    assign gpr_wen   = gpr_wen_q;
    assign gpr_waddr = gpr_waddr_q;
    assign gpr_wdata = gpr_wdata_q;

endmodule

// File: tb/tb_wbu_multi_port.sv
// Directed bench for wbu_multi_port (NUM_CH=2, DEPTH=4, XLEN=64): reset, single write,
// fairness, full-FIFO backpressure, x0 drop and flush.
module tb_wbu_multi_port;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [1:0]   ch_valid;
    logic [1:0]   ch_ready;
    logic [9:0]   ch_rd;
    logic [127:0] ch_data;
    logic         gpr_wen;
    logic [4:0]   gpr_waddr;
    logic [63:0]  gpr_wdata;
    logic [31:0]  rd_busy;

    int checks = 0;
    int errors = 0;

    wbu_multi_port #(
        .NUM_CH(2),
        .DEPTH (4),
        .XLEN  (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .ch_valid (ch_valid),
        .ch_ready (ch_ready),
        .ch_rd    (ch_rd),
        .ch_data  (ch_data),
        .gpr_wen  (gpr_wen),
        .gpr_waddr(gpr_waddr),
        .gpr_wdata(gpr_wdata),
        .rd_busy  (rd_busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        flush    = 1'b0;
        ch_valid = '0;
        ch_rd    = '0;
        ch_data  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({gpr_wen, gpr_waddr, gpr_wdata} !== {1'b0, 5'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset_gpr got wen=%b addr=%0d data=%h want 0/0/0",
                     gpr_wen, gpr_waddr, gpr_wdata);
        end
        checks++;
        if ({ch_ready, rd_busy} !== {2'b11, 32'd0}) begin
            errors++;
            $display("FAIL reset_ready_busy got ready=%b busy=%h want 11/0", ch_ready, rd_busy);
        end
        // Queue work, then hit reset mid-cycle.
        ch_valid = 2'b11;
        ch_rd    = {5'd7, 5'd6};
        tick();
        ch_valid = 2'b00;
        tick();
        checks++;
        if ({gpr_wen, gpr_waddr, rd_busy} !== {1'b1, 5'd7, 32'h0000_00C0}) begin
            errors++;
            $display("FAIL pre_reset got wen=%b addr=%0d busy=%h want 1/7/000000c0",
                     gpr_wen, gpr_waddr, rd_busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({gpr_wen, rd_busy, ch_ready} !== {1'b0, 32'd0, 2'b11}) begin
            errors++;
            $display("FAIL async_reset got wen=%b busy=%h ready=%b want 0/0/11",
                     gpr_wen, rd_busy, ch_ready);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single;
        do_reset();
        ch_valid = 2'b01;
        ch_rd    = {5'd0, 5'd5};
        ch_data  = {64'd0, 64'hDEAD_BEEF};
        tick();
        ch_valid = 2'b00;
        checks++;
        if ({gpr_wen, rd_busy} !== {1'b0, 32'h0000_0020}) begin
            errors++;
            $display("FAIL single_queued got wen=%b busy=%h want 0/00000020", gpr_wen, rd_busy);
        end
        tick();
        checks++;
        if ({gpr_wen, gpr_waddr, gpr_wdata, rd_busy} !==
            {1'b1, 5'd5, 64'hDEAD_BEEF, 32'h0000_0020}) begin
            errors++;
            $display("FAIL single_write got wen=%b addr=%0d data=%h busy=%h want 1/5/deadbeef/20",
                     gpr_wen, gpr_waddr, gpr_wdata, rd_busy);
        end
        tick();
        checks++;
        if ({gpr_wen, rd_busy} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL single_done got wen=%b busy=%h want 0/0", gpr_wen, rd_busy);
        end
    endtask

    task automatic test_fairness;
        logic [4:0] exp_addr;
        do_reset();
        ch_valid = 2'b11;
        ch_rd    = {5'd12, 5'd11};
        ch_data  = {64'h1111, 64'h0000};
        tick();
        checks++;
        if (gpr_wen !== 1'b0) begin
            errors++;
            $display("FAIL fair_first got wen=%b want 0", gpr_wen);
        end
        for (int k = 2; k <= 17; k++) begin
            tick();
            exp_addr = (k % 2 == 0) ? 5'd12 : 5'd11;
            checks++;
            if ({gpr_wen, gpr_waddr} !== {1'b1, exp_addr}) begin
                errors++;
                $display("FAIL fair_edge%0d got wen=%b addr=%0d want 1/%0d",
                         k, gpr_wen, gpr_waddr, exp_addr);
            end
        end
        ch_valid = 2'b00;
    endtask

    task automatic test_full;
        logic [7:0]  acc_tbl = 8'b1011_1111;
        logic [7:0]  rdy_tbl = 8'b0101_1111;
        logic [4:0]  exp_addr;
        logic [63:0] exp_data;
        int          n;
        n = 0;
        do_reset();
        ch_rd = {5'd9, 5'd7};
        for (int e = 1; e <= 15; e++) begin
            ch_valid = (e <= 8) ? 2'b11 : 2'b00;
            ch_data  = {64'h9999, 64'hA0 + 64'(n)};
            tick();
            if (e <= 8) begin
                checks++;
                if (ch_ready[0] !== rdy_tbl[e-1]) begin
                    errors++;
                    $display("FAIL full_ready_e%0d got %b want %b", e, ch_ready[0], rdy_tbl[e-1]);
                end
                if (acc_tbl[e-1]) n++;
            end
            if (e >= 2) begin
                exp_addr = (e % 2 == 1) ? 5'd7 : 5'd9;
                exp_data = (e % 2 == 1) ? 64'hA0 + 64'((e - 3) / 2) : 64'h9999;
                checks++;
                if ({gpr_wen, gpr_waddr, gpr_wdata} !== {1'b1, exp_addr, exp_data}) begin
                    errors++;
                    $display("FAIL full_out_e%0d got wen=%b addr=%0d data=%h want 1/%0d/%h",
                             e, gpr_wen, gpr_waddr, gpr_wdata, exp_addr, exp_data);
                end
            end
        end
        tick();
        checks++;
        if ({gpr_wen, rd_busy} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL full_drained got wen=%b busy=%h want 0/0", gpr_wen, rd_busy);
        end
    endtask

    task automatic test_x0;
        do_reset();
        ch_valid = 2'b01;
        ch_rd    = 10'd0;
        ch_data  = {64'd0, 64'h1234};
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++;
            if ({ch_ready, rd_busy, gpr_wen} !== {2'b11, 32'd0, 1'b0}) begin
                errors++;
                $display("FAIL x0_e%0d got ready=%b busy=%h wen=%b want 11/0/0",
                         e, ch_ready, rd_busy, gpr_wen);
            end
        end
        ch_valid = 2'b00;
        tick();
        checks++;
        if (gpr_wen !== 1'b0) begin
            errors++;
            $display("FAIL x0_after got wen=%b want 0", gpr_wen);
        end
    endtask

    task automatic test_flush;
        do_reset();
        ch_valid = 2'b11;
        ch_rd    = {5'd3, 5'd1};
        tick();
        ch_valid = 2'b01;
        ch_rd    = {5'd3, 5'd2};
        tick();
        checks++;
        if ({gpr_wen, gpr_waddr, rd_busy} !== {1'b1, 5'd3, 32'h0000_000E}) begin
            errors++;
            $display("FAIL flush_pre got wen=%b addr=%0d busy=%h want 1/3/0000000e",
                     gpr_wen, gpr_waddr, rd_busy);
        end
        flush    = 1'b1;
        ch_valid = 2'b11;
        ch_rd    = {5'd5, 5'd4};
        #1;
        checks++;
        if ({gpr_wen, gpr_waddr} !== {1'b1, 5'd3}) begin
            errors++;
            $display("FAIL flush_inflight got wen=%b addr=%0d want 1/3", gpr_wen, gpr_waddr);
        end
        tick();
        flush    = 1'b0;
        ch_valid = 2'b00;
        checks++;
        if ({gpr_wen, rd_busy, ch_ready} !== {1'b0, 32'd0, 2'b11}) begin
            errors++;
            $display("FAIL flush_after got wen=%b busy=%h ready=%b want 0/0/11",
                     gpr_wen, rd_busy, ch_ready);
        end
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if ({gpr_wen, rd_busy} !== {1'b0, 32'd0}) begin
                errors++;
                $display("FAIL flush_quiet%0d got wen=%b addr=%0d busy=%h want 0/x/0",
                         e, gpr_wen, gpr_waddr, rd_busy);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        ch_valid = '0;
        ch_rd    = '0;
        ch_data  = '0;
        test_reset();
        test_single();
        test_fairness();
        test_full();
        test_x0();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
